// File: rtl/train_agent.sv
// ---------------------------------------------------------------------------
// train_agent
//
// Junction agent for four trains that share one track segment. Each train
// runs its own IDLE -> WAIT -> CROSS state machine. An external traffic
// controller names the train that may use the track. A crossing finishes
// once the grant has been held for CROSS_CYCLES+1 consecutive edges. Only
// one train occupies the track at a time, so one occupancy counter is
// shared by all four trains.
//
// Parameters
//   CROSS_CYCLES   track occupancy length in clock cycles (1..15)
//
// Ports
//   clk            single clock, rising-edge active
//   reset          asynchronous, active-low reset
//   arrive[3:0]    bit i pulses when train i+1 reaches the junction
//   grant[2:0]     controller grant: 0 none, 1..4 train, 5..7 illegal
//   train_request  bit i high while train i+1 waits for or holds the track
//   train_done     one-cycle pulse when the current crossing completes
//   crossing_id    train currently on the track (1..4), 0 when free
//   crossed_count  completed crossings, saturating at 255
//   abort_count    crossings revoked by the controller, saturating at 255
//   arrive_drop    one-cycle pulse when an arrival is discarded
//   grant_error    sticky flag, set when an illegal grant value is sampled
// ---------------------------------------------------------------------------
module train_agent #(
  parameter int CROSS_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] arrive,
  input  logic [2:0] grant,
  output logic [3:0] train_request,
  output logic       train_done,
  output logic [2:0] crossing_id,
  output logic [7:0] crossed_count,
  output logic [7:0] abort_count,
  output logic       arrive_drop,
  output logic       grant_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CROSS = 2'd2
  } state_t;

  localparam logic [3:0] CROSS_LAST = 4'(CROSS_CYCLES);

  // Shared occupancy counter and registered outputs
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] request_reg, request_next;
  logic       done_reg, done_next;
  logic [2:0] crossing_id_reg, crossing_id_next;
  logic [7:0] crossed_count_reg, crossed_count_next;
  logic [7:0] abort_count_reg, abort_count_next;
  logic       drop_reg, drop_next;
  logic       grant_error_reg, grant_error_next;

  // Per-train event flags gathered from the generate blocks
  logic [3:0] start_vec;
  logic [3:0] step_vec;
  logic [3:0] done_vec;
  logic [3:0] abort_vec;
  logic [3:0] drop_vec;
  logic [3:0] cross_vec;
  logic [3:0] cross_next_vec;
  logic [3:0] busy_next_vec;

  logic       grant_illegal;
  logic [2:0] grant_eff;
  logic       any_cross;

  // Illegal grant codes behave exactly like "no grant" for the FSMs.
  assign grant_illegal = (grant > 3'd4);
  assign grant_eff     = grant_illegal ? 3'd0 : grant;
  assign any_cross     = |cross_vec;

  for (genvar gi = 0; gi < 4; gi++) begin : g_train
    localparam logic [2:0] TRAIN_ID = 3'(gi + 1);

    state_t state_reg, state_next;
    logic   granted;
    logic   start_ev, step_ev, done_ev, abort_ev, drop_ev;

    assign granted = (grant_eff == TRAIN_ID);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg <= IDLE;
      end else begin
        state_reg <= state_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      start_ev   = 1'b0;
      step_ev    = 1'b0;
      done_ev    = 1'b0;
      abort_ev   = 1'b0;
      drop_ev    = 1'b0;
      case (state_reg)
        IDLE: begin
          // A grant naming an idle train is simply ignored.
          if (arrive[gi]) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          drop_ev = arrive[gi];
          // Entry is blocked while any other train still holds the track,
          // even if that train is being revoked on this same edge.
          if (granted && !any_cross) begin
            state_next = CROSS;
            start_ev   = 1'b1;
          end
        end
        CROSS: begin
          // Arrivals are discarded here too, including on the completion edge.
          drop_ev = arrive[gi];
          if (granted) begin
            if (cnt_reg == CROSS_LAST) begin
              state_next = IDLE;
              done_ev    = 1'b1;
            end else begin
              step_ev = 1'b1;
            end
          end else begin
            state_next = WAIT;
            abort_ev   = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    assign start_vec[gi]      = start_ev;
    assign step_vec[gi]       = step_ev;
    assign done_vec[gi]       = done_ev;
    assign abort_vec[gi]      = abort_ev;
    assign drop_vec[gi]       = drop_ev;
    assign cross_vec[gi]      = (state_reg == CROSS);
    assign cross_next_vec[gi] = (state_next == CROSS);
    assign busy_next_vec[gi]  = (state_next != IDLE);
  end

  // Next values for the shared counter and every registered output
  always_comb begin
    cnt_next           = cnt_reg;
    request_next       = busy_next_vec;
    done_next          = |done_vec;
    drop_next          = |drop_vec;
    crossing_id_next   = 3'd0;
    crossed_count_next = crossed_count_reg;
    abort_count_next   = abort_count_reg;
    grant_error_next   = grant_error_reg | grant_illegal;

    if (|start_vec) begin
      cnt_next = 4'd1;
    end else if (|step_vec) begin
      cnt_next = cnt_reg + 4'd1;
    end else if ((|done_vec) || (|abort_vec)) begin
      cnt_next = 4'd0;
    end

    // At most one train can be in CROSS after this edge.
    for (int i = 0; i < 4; i++) begin
      if (cross_next_vec[i]) begin
        crossing_id_next = 3'(i + 1);
      end
    end

    if ((|done_vec) && (crossed_count_reg != 8'hFF)) begin
      crossed_count_next = crossed_count_reg + 8'd1;
    end
    if ((|abort_vec) && (abort_count_reg != 8'hFF)) begin
      abort_count_next = abort_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg           <= 4'd0;
      request_reg       <= 4'd0;
      done_reg          <= 1'b0;
      crossing_id_reg   <= 3'd0;
      crossed_count_reg <= 8'd0;
      abort_count_reg   <= 8'd0;
      drop_reg          <= 1'b0;
      grant_error_reg   <= 1'b0;
    end else begin
      cnt_reg           <= cnt_next;
      request_reg       <= request_next;
      done_reg          <= done_next;
      crossing_id_reg   <= crossing_id_next;
      crossed_count_reg <= crossed_count_next;
      abort_count_reg   <= abort_count_next;
      drop_reg          <= drop_next;
      grant_error_reg   <= grant_error_next;
    end
  end

  assign train_request = request_reg;
  assign train_done    = done_reg;
  assign crossing_id   = crossing_id_reg;
  assign crossed_count = crossed_count_reg;
  assign abort_count   = abort_count_reg;
  assign arrive_drop   = drop_reg;
  assign grant_error   = grant_error_reg;

endmodule

// File: tb/tb_train_agent.sv
// ---------------------------------------------------------------------------
// tb_train_agent
//
// Directed self-checking bench for train_agent with CROSS_CYCLES=3.
// Inputs change 1 ns after a rising edge, and outputs are checked at that
// same point. Every expected value is hand-computed from the requirements.
// ---------------------------------------------------------------------------
module tb_train_agent;

  logic       clk;
  logic       reset;
  logic [3:0] arrive;
  logic [2:0] grant;
  logic [3:0] train_request;
  logic       train_done;
  logic [2:0] crossing_id;
  logic [7:0] crossed_count;
  logic [7:0] abort_count;
  logic       arrive_drop;
  logic       grant_error;

  int errors = 0;
  int checks = 0;

  train_agent #(.CROSS_CYCLES(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .arrive        (arrive),
    .grant         (grant),
    .train_request (train_request),
    .train_done    (train_done),
    .crossing_id   (crossing_id),
    .crossed_count (crossed_count),
    .abort_count   (abort_count),
    .arrive_drop   (arrive_drop),
    .grant_error   (grant_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s = %0h", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One call compares all seven outputs against hand-computed values.
  task automatic chk_all(input string tag, input logic [3:0] req, input logic done,
                         input logic [2:0] cid, input logic [7:0] crossed,
                         input logic [7:0] aborted, input logic drop, input logic gerr);
    chk({tag, ".train_request"}, 32'(train_request), 32'(req));
    chk({tag, ".train_done"},    32'(train_done),    32'(done));
    chk({tag, ".crossing_id"},   32'(crossing_id),   32'(cid));
    chk({tag, ".crossed_count"}, 32'(crossed_count), 32'(crossed));
    chk({tag, ".abort_count"},   32'(abort_count),   32'(aborted));
    chk({tag, ".arrive_drop"},   32'(arrive_drop),   32'(drop));
    chk({tag, ".grant_error"},   32'(grant_error),   32'(gerr));
  endtask

  initial begin
    reset  = 1'b0;
    arrive = 4'b0000;
    grant  = 3'd0;

    // Reset held for two cycles: every output must read zero.
    step();
    step();
    chk_all("reset", 4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    reset = 1'b1;
    step();
    chk_all("idle_after_reset", 4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Train 1 arrives and then waits with no grant.
    arrive = 4'b0001;
    step();
    arrive = 4'b0000;
    chk_all("t1_arrive", 4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    step();
    chk_all("t1_waiting", 4'b0001, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Grant 1 held: CROSS after edge 1, done after edge 4.
    grant = 3'd1;
    step();
    chk_all("t1_edge1", 4'b0001, 1'b0, 3'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    step();
    chk_all("t1_edge3", 4'b0001, 1'b0, 3'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("t1_edge4_done", 4'b0000, 1'b1, 3'd0, 8'd1, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("t1_grant_held_1", 4'b0000, 1'b0, 3'd0, 8'd1, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("t1_grant_held_2", 4'b0000, 1'b0, 3'd0, 8'd1, 8'd0, 1'b0, 1'b0);
    grant = 3'd0;

    // Train 2 is revoked with cnt=2, then completes a full crossing.
    arrive = 4'b0010;
    step();
    arrive = 4'b0000;
    chk_all("t2_arrive", 4'b0010, 1'b0, 3'd0, 8'd1, 8'd0, 1'b0, 1'b0);
    grant = 3'd2;
    step();
    step();
    chk_all("t2_cnt2", 4'b0010, 1'b0, 3'd2, 8'd1, 8'd0, 1'b0, 1'b0);
    grant = 3'd0;
    step();
    chk_all("t2_revoked", 4'b0010, 1'b0, 3'd0, 8'd1, 8'd1, 1'b0, 1'b0);
    grant = 3'd2;
    step();
    step();
    step();
    chk_all("t2_retry_edge3", 4'b0010, 1'b0, 3'd2, 8'd1, 8'd1, 1'b0, 1'b0);
    step();
    chk_all("t2_retry_done", 4'b0000, 1'b1, 3'd0, 8'd2, 8'd1, 1'b0, 1'b0);
    grant = 3'd0;
    step();
    chk_all("t2_after_done", 4'b0000, 1'b0, 3'd0, 8'd2, 8'd1, 1'b0, 1'b0);

    // Two trains arrive on one edge, then a repeat arrival is dropped.
    arrive = 4'b1010;
    step();
    chk_all("dual_arrive", 4'b1010, 1'b0, 3'd0, 8'd2, 8'd1, 1'b0, 1'b0);
    arrive = 4'b1000;
    step();
    chk_all("t4_repeat_drop", 4'b1010, 1'b0, 3'd0, 8'd2, 8'd1, 1'b1, 1'b0);
    arrive = 4'b0000;
    step();
    chk_all("drop_one_cycle", 4'b1010, 1'b0, 3'd0, 8'd2, 8'd1, 1'b0, 1'b0);

    // Train 2 completes with its own arrival on the completion edge: dropped.
    grant = 3'd2;
    step();
    step();
    step();
    arrive = 4'b0010;
    step();
    arrive = 4'b0000;
    chk_all("t2_done_with_drop", 4'b1000, 1'b1, 3'd0, 8'd3, 8'd1, 1'b1, 1'b0);
    grant = 3'd3;
    step();
    chk_all("grant_idle_t3", 4'b1000, 1'b0, 3'd0, 8'd3, 8'd1, 1'b0, 1'b0);

    // Train 3 crossing aborted by illegal grant 6; grant_error is sticky.
    arrive = 4'b0100;
    grant  = 3'd0;
    step();
    arrive = 4'b0000;
    chk_all("t3_arrive", 4'b1100, 1'b0, 3'd0, 8'd3, 8'd1, 1'b0, 1'b0);
    grant = 3'd3;
    step();
    step();
    chk_all("t3_cnt2", 4'b1100, 1'b0, 3'd3, 8'd3, 8'd1, 1'b0, 1'b0);
    grant = 3'd6;
    step();
    chk_all("t3_illegal_abort", 4'b1100, 1'b0, 3'd0, 8'd3, 8'd2, 1'b0, 1'b1);
    grant = 3'd0;
    step();
    chk_all("gerr_sticky", 4'b1100, 1'b0, 3'd0, 8'd3, 8'd2, 1'b0, 1'b1);

    // Repeated enter/revoke cycles push abort_count into saturation.
    for (int i = 0; i < 260; i++) begin
      grant = 3'd3;
      step();
      grant = 3'd0;
      step();
    end
    chk_all("abort_saturated", 4'b1100, 1'b0, 3'd0, 8'd3, 8'd255, 1'b0, 1'b1);

    // Reset asserted mid-crossing clears everything at once.
    grant = 3'd3;
    step();
    chk("t3_cross_before_reset", 32'(crossing_id), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk_all("reset_held", 4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_all("post_reset_grant_ignored", 4'b0000, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/train_agent.md
TRAIN_AGENT -- requirements
Module: train_agent

Interface
REQ-001 Parameter: CROSS_CYCLES, 3, track-occupancy length in clock cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 arrive  input  4  bit i = one-cycle pulse, train i+1 reaches the junction.
REQ-005 grant  input  3  from traffic controller; 0 = none, 1..4 = train 1..4, 5..7 = illegal.
REQ-006 train_request  output  4  bit i high while train i+1 is waiting for or holding the track.
REQ-007 train_done  output  1  one-cycle pulse, the current crossing has completed.
REQ-008 crossing_id  output  3  train currently on track (1..4); 0 = track free.
REQ-009 crossed_count  output  8  completed crossings; saturates at 255.
REQ-010 abort_count  output  8  crossings revoked by the controller; saturates at 255.
REQ-011 arrive_drop  output  1  one-cycle pulse, an arrival was discarded.
REQ-012 grant_error  output  1  sticky flag, an illegal grant value was sampled.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Each train SHALL have its own FSM with states IDLE, WAIT and CROSS.
- Only one train SHALL be in CROSS at a time.
- A single shared 4-bit cross counter cnt SHALL be used.
REQ-015 IDLE SHALL move to WAIT on an edge sampling arrive[i]=1; train_request[i] SHALL be 1 from that edge onward.
REQ-016 WAIT SHALL move to CROSS on an edge sampling grant==i+1, provided no train is in CROSS.
- On that edge: cnt=1, crossing_id=i+1.
REQ-017 In CROSS, on each edge sampling grant==i+1:
- If cnt==CROSS_CYCLES: go to IDLE; pulse train_done; clear train_request[i]; set crossing_id=0; increment crossed_count.
- Otherwise: cnt=cnt+1.
- Net effect: train_done is asserted after the (CROSS_CYCLES+1)th consecutive edge sampling the grant.
REQ-018 In CROSS, on an edge sampling grant!=i+1 (revocation or timeout):
- Go to WAIT; train_request[i] stays 1; cnt=0; crossing_id=0; increment abort_count.
- No train_done pulse.
REQ-019 A grant naming a train in IDLE SHALL be ignored, including a grant still held in the cycles after train_done.
REQ-020 Grant values 5..7 SHALL be treated as 0 (for example, they abort a CROSS) and SHALL set grant_error until reset.
REQ-021 arrive[i] sampled while train i+1 is in WAIT or CROSS SHALL be discarded and pulse arrive_drop.
- This includes the edge on which that train completes.
REQ-022 Arrivals for different trains on the same edge SHALL each be accepted independently.
REQ-023 train_done and arrive_drop SHALL never be high for two consecutive cycles due to one event.
REQ-024 Counters SHALL saturate, not wrap.

Reset
REQ-025 While reset=0, asynchronously and regardless of state:
- All FSMs go to IDLE and cnt=0.
- train_request=4'b0000, train_done=0, crossing_id=3'd0, crossed_count=0, abort_count=0, arrive_drop=0, grant_error=0.
REQ-026 Reset asserted mid-crossing SHALL discard the crossing with no train_done pulse and no count update.
REQ-027 The first state change after reset release SHALL be on the first rising edge that samples reset=1.

Verification (CROSS_CYCLES=3)
REQ-028 Reset held 2 cycles, arrive=0, grant=0 -> all outputs 0; then arrive=4'b0001 for 1 cycle -> train_request=4'b0001 and stays there with grant=0.
REQ-029 Train 1 waiting, grant=1 held -> crossing_id=1 after the first edge; train_done high for exactly 1 cycle after the 4th grant edge; train_request=0; crossed_count=1; grant=1 held further -> no change.
REQ-030 Train 2 in CROSS with cnt=2, grant drops to 0 -> train_request=4'b0010, crossing_id=0, abort_count=1, no train_done; grant=2 again -> full 4-edge crossing, then done.
REQ-031 arrive=4'b1010 on one edge -> train_request=4'b1010; arrive[3] pulsed again while waiting -> arrive_drop 1 cycle, train_request unchanged.
REQ-032 grant=3'd6 while train 3 is in CROSS -> abort, abort_count+1, grant_error=1 and it persists; reset asserted mid-CROSS -> all outputs 0 immediately, crossed_count=0.
